// File: rtl/xyolo_vmac_pkg.sv
// xyolo_vmac_pkg: shared constants and types for the YOLO vector MAC stage.
// Holds the CPU register map, FSM state encoding and the lane tag bundle.
// The optional leaky-ReLU register (XYOLO_VMAC_CONF_LEAKY) is only decoded when
// XYOLO_VMAC_LEAKY_EN is defined.
package xyolo_vmac_pkg;

    localparam int XYOLO_VMAC_ADDR_W = 3;

    localparam logic [XYOLO_VMAC_ADDR_W-1:0] XYOLO_VMAC_CONF_ITER    = 3'd0;
    localparam logic [XYOLO_VMAC_ADDR_W-1:0] XYOLO_VMAC_CONF_ACC_LEN = 3'd1;
    localparam logic [XYOLO_VMAC_ADDR_W-1:0] XYOLO_VMAC_CONF_DELAY   = 3'd2;
    localparam logic [XYOLO_VMAC_ADDR_W-1:0] XYOLO_VMAC_CONF_SHIFT   = 3'd3;
    localparam logic [XYOLO_VMAC_ADDR_W-1:0] XYOLO_VMAC_CONF_LEAKY   = 3'd4;

    // Cycles spent in DRAIN so the last result leaves the lane pipeline first.
    localparam int XYOLO_VMAC_DRAIN_CYCLES = 3;

    // Leaky ReLU slope for negative values is 2^-XYOLO_VMAC_LEAKY_SHIFT.
    localparam int XYOLO_VMAC_LEAKY_SHIFT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ACC   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Control tags that travel alongside each operand set through the lanes.
    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } tag_t;

endpackage

// File: rtl/xyolo_vmac_if.sv
// xyolo_vmac_if: request-only CPU configuration port shared by the Versat YOLO
// stages. A register write happens on valid & wstrb.
interface xyolo_vmac_if
    import xyolo_vmac_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic                         valid;
    logic [XYOLO_VMAC_ADDR_W-1:0] addr;
    logic [CNT_W-1:0]             wdata;
    logic                         wstrb;

    modport master (output valid, addr, wdata, wstrb);
    modport slave  (input  valid, addr, wdata, wstrb);
endinterface

// File: rtl/xyolo_vmac_lane.sv
// xyolo_vmac_lane: one multiply-accumulate lane.
//   stage 1: product = weight * pixel, bias captured on the first element
//   stage 2: accumulate (restart from bias on the first element)
//   stage 3: arithmetic shift, optional leaky ReLU, saturate, strobe on last
// Leaky ReLU hardware and its enable port exist only with XYOLO_VMAC_LEAKY_EN.
module xyolo_vmac_lane
    import xyolo_vmac_pkg::*;
#(
    parameter int DATAPATH_W = 32,
    parameter int ACC_W      = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  tag_t                         tag_i,
    input  logic signed [DATAPATH_W-1:0] pixel_i,
    input  logic signed [DATAPATH_W-1:0] weight_i,
    input  logic signed [DATAPATH_W-1:0] bias_i,
    input  logic        [5:0]            shift_i,
`ifdef XYOLO_VMAC_LEAKY_EN
    input  logic                         leaky_i,
`endif
    output logic        [DATAPATH_W-1:0] out_o,
    output logic                         out_valid_o
);

    localparam int PROD_W = 2 * DATAPATH_W;

    // Output clamp limits expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATAPATH_W+1){1'b0}}, {(DATAPATH_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    tag_t                         tag1_q;
    tag_t                         tag2_q;
    logic signed [PROD_W-1:0]     prod_q;
    logic signed [DATAPATH_W-1:0] bias_q;
    logic signed [ACC_W-1:0]      acc_q;
    logic signed [ACC_W-1:0]      prod_ext;
    logic signed [ACC_W-1:0]      bias_ext;
    logic signed [ACC_W-1:0]      shifted;
    logic signed [ACC_W-1:0]      act;
    logic        [DATAPATH_W-1:0] out_d;
    logic        [DATAPATH_W-1:0] out_q;
    logic                         out_valid_q;

    // Tag pipeline: reset wipes in-flight tags so an aborted run never strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag1_q <= '0;
            tag2_q <= '0;
        end else begin
            tag1_q <= tag_i;
            tag2_q <= tag1_q;
        end
    end

    // Stage 1: register the signed product and capture bias on a window's first element.
    // NOTE: datapath registers carry no reset; the tags alone decide when their contents are used.
    always_ff @(posedge clk) begin
        if (tag_i.vld) begin
            prod_q <= PROD_W'(weight_i) * PROD_W'(pixel_i);
            if (tag_i.first) begin
                bias_q <= bias_i;
            end
        end
    end

    assign prod_ext = ACC_W'(prod_q);
    assign bias_ext = ACC_W'(bias_q);

    // Stage 2: restart from bias on the first element, otherwise keep accumulating (wraps).
    always_ff @(posedge clk) begin
        if (tag1_q.vld) begin
            acc_q <= tag1_q.first ? (bias_ext + prod_ext) : (acc_q + prod_ext);
        end
    end

    // Stage 3 combinational: shift, optional activation, clamp to the output range.
    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    always_comb begin
        shifted = acc_q >>> shift_i;
        act     = shifted;
`ifdef XYOLO_VMAC_LEAKY_EN
        if (leaky_i && shifted[ACC_W-1]) begin
            act = shifted >>> XYOLO_VMAC_LEAKY_SHIFT;
        end
`endif
        if (act > SAT_MAX) begin
            out_d = SAT_MAX[DATAPATH_W-1:0];
        end else if (act < SAT_MIN) begin
            out_d = SAT_MIN[DATAPATH_W-1:0];
        end else begin
            out_d = act[DATAPATH_W-1:0];
        end
    end

    // Stage 3 register: capture the result on a window's last element; hold it otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= tag2_q.vld & tag2_q.last;
            if (tag2_q.vld && tag2_q.last) begin
                out_q <= out_d;
            end
        end
    end

    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: rtl/xyolo_vmac.sv
// xyolo_vmac: vector multiply-accumulate stage fed by the YOLO weight/bias reader.
// Holds configuration and shadow registers, the run/done FSM and the element,
// window and delay counters; broadcasts per-cycle tags to N_LANES lanes.
// Define XYOLO_VMAC_LEAKY_EN to add the LEAKY_ON register and leaky ReLU.
module xyolo_vmac
    import xyolo_vmac_pkg::*;
#(
    parameter int DATAPATH_W = 32,
    parameter int N_LANES    = 8,
    parameter int ACC_W      = 64,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          run,
    output logic                          done,
    xyolo_vmac_if.slave                   cpu,
    input  logic [DATAPATH_W-1:0]         flow_in_pixel,
    input  logic [N_LANES*DATAPATH_W-1:0] flow_in_weight,
    input  logic [N_LANES*DATAPATH_W-1:0] flow_in_bias,
    output logic [N_LANES*DATAPATH_W-1:0] flow_out,
    output logic                          flow_out_valid
);

    logic [CNT_W-1:0] iter_q, acc_len_q, delay_q;
    logic [5:0]       shift_q;
    logic [CNT_W-1:0] sh_iter_q, sh_acc_len_q, sh_delay_q;
    logic [5:0]       sh_shift_q;
`ifdef XYOLO_VMAC_LEAKY_EN
    logic             leaky_q;
    logic             sh_leaky_q;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] dly_q, dly_d;
    logic [CNT_W-1:0] elem_q, elem_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic [1:0]       drain_q, drain_d;

    logic             cpu_wr;
    logic             start_ok;
    logic             last_elem;
    logic             last_win;
    tag_t             acc_tag;
    logic [N_LANES-1:0] lane_valid;

    assign cpu_wr   = cpu.valid & cpu.wstrb;
    assign start_ok = (iter_q != '0) && (acc_len_q != '0);

    // CPU-visible configuration registers; clear wipes them but never the shadows.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            iter_q    <= '0;
            acc_len_q <= '0;
            delay_q   <= '0;
            shift_q   <= '0;
`ifdef XYOLO_VMAC_LEAKY_EN
            leaky_q   <= 1'b0;
`endif
        end else if (cpu_wr) begin
            case (cpu.addr)
                XYOLO_VMAC_CONF_ITER:    iter_q    <= cpu.wdata;
                XYOLO_VMAC_CONF_ACC_LEN: acc_len_q <= cpu.wdata;
                XYOLO_VMAC_CONF_DELAY:   delay_q   <= cpu.wdata;
                XYOLO_VMAC_CONF_SHIFT:   shift_q   <= cpu.wdata[5:0];
`ifdef XYOLO_VMAC_LEAKY_EN
                XYOLO_VMAC_CONF_LEAKY:   leaky_q   <= cpu.wdata[0];
`endif
                default: ;
            endcase
        end
    end

    // Shadow copy taken on run in IDLE; the active run only ever reads these.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_iter_q    <= '0;
            sh_acc_len_q <= '0;
            sh_delay_q   <= '0;
            sh_shift_q   <= '0;
`ifdef XYOLO_VMAC_LEAKY_EN
            sh_leaky_q   <= 1'b0;
`endif
        end else if (run && (state_q == ST_IDLE)) begin
            sh_iter_q    <= iter_q;
            sh_acc_len_q <= acc_len_q;
            sh_delay_q   <= delay_q;
            sh_shift_q   <= shift_q;
`ifdef XYOLO_VMAC_LEAKY_EN
            sh_leaky_q   <= leaky_q;
`endif
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dly_q   <= '0;
            elem_q  <= '0;
            win_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            elem_q  <= elem_d;
            win_q   <= win_d;
            drain_q <= drain_d;
        end
    end

    assign last_elem = (elem_q == sh_acc_len_q - CNT_W'(1));
    assign last_win  = (win_q == sh_iter_q - CNT_W'(1));

    // Next-state logic: IDLE -> WAIT -> ACC (windows x elements) -> DRAIN -> IDLE.
    // NOTE: combinational blocks use blocking '=', clocked blocks use non-blocking '<='.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        elem_d  = elem_q;
        win_d   = win_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (run && start_ok) begin
                    state_d = ST_WAIT;
                    dly_d   = '0;
                end
            end
            ST_WAIT: begin
                // WAIT always lasts at least one cycle; DELAY 0 and 1 behave alike.
                if (dly_q + CNT_W'(1) >= sh_delay_q) begin
                    state_d = ST_ACC;
                    elem_d  = '0;
                    win_d   = '0;
                end else begin
                    dly_d = dly_q + CNT_W'(1);
                end
            end
            ST_ACC: begin
                if (last_elem) begin
                    elem_d = '0;
                    if (last_win) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end else begin
                        win_d = win_q + CNT_W'(1);
                    end
                end else begin
                    elem_d = elem_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == 2'(XYOLO_VMAC_DRAIN_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Tags broadcast to every lane for the operand set presented this cycle.
    always_comb begin
        acc_tag.vld   = (state_q == ST_ACC);
        acc_tag.first = (elem_q == '0);
        acc_tag.last  = last_elem;
    end

    assign done = (state_q == ST_IDLE);

    // Lane i occupies the i-th word from the MSB end of every vector bus.
    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        localparam int LSB = (N_LANES - 1 - i) * DATAPATH_W;
        xyolo_vmac_lane #(
            .DATAPATH_W (DATAPATH_W),
            .ACC_W      (ACC_W)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .tag_i       (acc_tag),
            .pixel_i     (flow_in_pixel),
            .weight_i    (flow_in_weight[LSB +: DATAPATH_W]),
            .bias_i      (flow_in_bias[LSB +: DATAPATH_W]),
            .shift_i     (sh_shift_q),
`ifdef XYOLO_VMAC_LEAKY_EN
            .leaky_i     (sh_leaky_q),
`endif
            .out_o       (flow_out[LSB +: DATAPATH_W]),
            .out_valid_o (lane_valid[i])
        );
    end

    // All lanes see identical tags, so their strobes coincide.
    assign flow_out_valid = &lane_valid;

endmodule

// File: tb/tb_xyolo_vmac.sv
// tb_xyolo_vmac: scoreboard bench for xyolo_vmac. Expected output vectors and
// their strobe cycles are pushed when a run is issued and popped on each strobe.
// Build with XYOLO_VMAC_LEAKY_EN to exercise the leaky ReLU option.
module tb_xyolo_vmac;
    import xyolo_vmac_pkg::*;

    localparam int DW    = 32;
    localparam int N     = 8;
    localparam int ACC_W = 64;
    localparam int CNT_W = 16;
    localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint SMIN = -64'sh0000_0000_8000_0000;

    typedef struct {
        logic [N*DW-1:0] data;
        int              cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            clear;
    logic            run;
    logic            done;
    logic [DW-1:0]   pixel;
    logic [N*DW-1:0] weight_vec;
    logic [N*DW-1:0] bias_vec;
    logic [N*DW-1:0] flow_out;
    logic            flow_out_valid;

    logic signed [DW-1:0] w_arr [N];
    logic signed [DW-1:0] b_arr [N];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];

    int cfg_iter, cfg_len, cfg_delay, cfg_shift;
    bit cfg_leaky;

    xyolo_vmac_if #(.CNT_W(CNT_W)) cpu ();

    xyolo_vmac #(
        .DATAPATH_W (DW),
        .N_LANES    (N),
        .ACC_W      (ACC_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .run            (run),
        .done           (done),
        .cpu            (cpu),
        .flow_in_pixel  (pixel),
        .flow_in_weight (weight_vec),
        .flow_in_bias   (bias_vec),
        .flow_out       (flow_out),
        .flow_out_valid (flow_out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        weight_vec = '0;
        bias_vec   = '0;
        for (int i = 0; i < N; i++) begin
            weight_vec[(N-1-i)*DW +: DW] = w_arr[i];
            bias_vec[(N-1-i)*DW +: DW]   = b_arr[i];
        end
    end

    // Reference for one lane: bias + len*(w*p), wrap at 64 bits, shift, activate, clamp.
    function automatic logic [DW-1:0] model_lane(input longint bias, input longint w,
                                                 input longint p, input int len,
                                                 input int shift, input bit leaky);
        longint acc;
        longint v;
        acc = bias + longint'(len) * (w * p);
        v = acc >>> shift;
        if (leaky && v < 0) v = v >>> 3;
        if (v > SMAX) v = SMAX;
        else if (v < SMIN) v = SMIN;
        return v[DW-1:0];
    endfunction

    function automatic logic [N*DW-1:0] make_expected();
        logic [N*DW-1:0] vec;
        vec = '0;
        for (int i = 0; i < N; i++) begin
            vec[(N-1-i)*DW +: DW] = model_lane(longint'(b_arr[i]), longint'(w_arr[i]),
                                               longint'($signed(pixel)), cfg_len,
                                               cfg_shift, cfg_leaky);
        end
        return vec;
    endfunction

    task automatic write_cfg(input logic [2:0] a, input logic [CNT_W-1:0] d);
        cpu.valid = 1'b1;
        cpu.wstrb = 1'b1;
        cpu.addr  = a;
        cpu.wdata = d;
        @(negedge clk);
        cpu.valid = 1'b0;
        cpu.wstrb = 1'b0;
        case (a)
            3'd0: cfg_iter  = int'(d);
            3'd1: cfg_len   = int'(d);
            3'd2: cfg_delay = int'(d);
            3'd3: cfg_shift = int'(d[5:0]);
            3'd4: begin
`ifdef XYOLO_VMAC_LEAKY_EN
                cfg_leaky = d[0];
`endif
            end
            default: ;
        endcase
    endtask

    task automatic configure(input int iter, input int len, input int delay, input int shift);
        write_cfg(3'd0, CNT_W'(iter));
        write_cfg(3'd1, CNT_W'(len));
        write_cfg(3'd2, CNT_W'(delay));
        write_cfg(3'd3, CNT_W'(shift));
    endtask

    // Pulse run and queue one expected vector per window with its strobe cycle.
    task automatic start_run();
        int c0;
        int wt;
        logic [N*DW-1:0] vec;
        c0 = cyc;
        run = 1'b1;
        if (cfg_iter != 0 && cfg_len != 0) begin
            wt  = (cfg_delay == 0) ? 1 : cfg_delay;
            vec = make_expected();
            for (int w = 0; w < cfg_iter; w++) begin
                sb.push_back('{data: vec, cyc: c0 + wt + (w + 1) * cfg_len + 3});
            end
        end
        @(negedge clk);
        run = 1'b0;
    endtask

    // Pop and compare n strobes within budget cycles, then watch idle cycles for strays.
    task automatic collect(input int n, input int idle, input int budget);
        exp_t e;
        int   got;
        int   t;
        got = 0;
        t   = 0;
        while (got < n && t < budget) begin
            @(negedge clk);
            t++;
            if (flow_out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL stray_strobe cyc=%0d flow_out=%h", cyc, flow_out);
                end else begin
                    e = sb.pop_front();
                    got++;
                    n_cmp++;
                    if (flow_out !== e.data) begin
                        n_fail++;
                        $display("FAIL strobe_data got=%h want=%h", flow_out, e.data);
                    end
                    n_cmp++;
                    if (cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL strobe_cycle got=%0d want=%0d", cyc, e.cyc);
                    end
                end
            end
        end
        if (got < n) begin
            n_cmp++;
            n_fail++;
            $display("FAIL strobe_timeout got=%0d want=%0d strobes", got, n);
        end
        for (int k = 0; k < idle; k++) begin
            @(negedge clk);
            n_cmp++;
            if (flow_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL no_strobe cyc=%0d valid=%b want=0", cyc, flow_out_valid);
            end
        end
    endtask

    task automatic set_all(input logic signed [DW-1:0] w, input logic signed [DW-1:0] b);
        for (int i = 0; i < N; i++) begin
            w_arr[i] = w;
            b_arr[i] = b;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_done got=%b want=1", done);
        end
        n_cmp++;
        if (flow_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got=%b want=0", flow_out_valid);
        end
        n_cmp++;
        if (flow_out !== '0) begin
            n_fail++;
            $display("FAIL reset_flow_out got=%h want=0", flow_out);
        end
    endtask

    task automatic test_basic();
        logic [N*DW-1:0] want;
        configure(1, 4, 0, 0);
        pixel = 32'd2;
        set_all(32'sd3, 32'sd5);
        want = make_expected();
        start_run();
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy got=%b want=0", done);
        end
        collect(1, 0, 50);
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_at_strobe got=%b want=0", done);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done_after got=%b want=1", done);
        end
        pixel = 32'd9;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (flow_out !== want) begin
            n_fail++;
            $display("FAIL basic_hold got=%h want=%h", flow_out, want);
        end
    endtask

    task automatic test_lanes();
        configure(3, 1, 3, 0);
        pixel = 32'd10;
        for (int i = 0; i < N; i++) begin
            w_arr[i] = DW'(i);
            b_arr[i] = '0;
        end
        start_run();
        collect(3, 4, 60);
    endtask

    task automatic test_saturate();
        configure(1, 4, 0, 4);
        pixel = 32'h0000_0100;
        for (int i = 0; i < N; i++) begin
            if (i % 2 == 0) begin
                w_arr[i] = 32'sh1000_0000;
                b_arr[i] = 32'sh7FFF_FFFF;
            end else begin
                w_arr[i] = 32'shF000_0000;
                b_arr[i] = 32'sh8000_0000;
            end
        end
        w_arr[6] = 32'sd1;
        b_arr[6] = 32'sh0000_0100;
        start_run();
        collect(1, 3, 50);
    endtask

    task automatic check_idle_run(input string tag);
        bit bad;
        start_run();
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done !== 1'b1 || flow_out_valid !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_fail++;
            $display("FAIL %s done=%b valid=%b want done=1 valid=0", tag, done, flow_out_valid);
        end
    endtask

    task automatic test_degenerate();
        pixel = 32'd1;
        set_all(32'sd1, 32'sd1);
        configure(0, 4, 0, 0);
        check_idle_run("iter_zero");
        configure(2, 0, 0, 0);
        check_idle_run("acc_len_zero");
    endtask

    task automatic test_ignore_run_and_clear();
        configure(2, 6, 0, 0);
        pixel = 32'd3;
        for (int i = 0; i < N; i++) begin
            w_arr[i] = DW'(i + 1);
            b_arr[i] = -DW'(i);
        end
        start_run();
        repeat (4) @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        write_cfg(3'd0, 16'd7);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        cfg_iter  = 0;
        cfg_len   = 0;
        cfg_delay = 0;
        cfg_shift = 0;
        cfg_leaky = 1'b0;
        collect(2, 12, 100);
        check_idle_run("after_clear");
    endtask

    task automatic test_reset_midrun();
        configure(4, 4, 0, 0);
        pixel = 32'd1;
        for (int i = 0; i < N; i++) begin
            w_arr[i] = 32'sd1;
            b_arr[i] = DW'(i);
        end
        start_run();
        collect(1, 0, 50);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (flow_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_valid got=%b want=0", flow_out_valid);
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_done got=%b want=1", done);
        end
        rst = 1'b0;
        sb.delete();
        cfg_iter  = 0;
        cfg_len   = 0;
        cfg_delay = 0;
        cfg_shift = 0;
        cfg_leaky = 1'b0;
        collect(0, 12, 1);
        configure(2, 2, 1, 1);
        pixel = 32'd5;
        for (int i = 0; i < N; i++) begin
            w_arr[i] = DW'(i) - 32'sd3;
            b_arr[i] = 32'sd7;
        end
        start_run();
        collect(2, 3, 50);
    endtask

    task automatic test_leaky();
        configure(1, 1, 0, 0);
        pixel = '0;
        for (int i = 0; i < N; i++) begin
            w_arr[i] = '0;
            b_arr[i] = (i % 2 == 0) ? -32'sd64 : 32'sd40;
        end
        write_cfg(3'd4, 16'd1);
        start_run();
        collect(1, 2, 30);
        write_cfg(3'd4, 16'd0);
        start_run();
        collect(1, 2, 30);
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        run       = 1'b0;
        pixel     = '0;
        cpu.valid = 1'b0;
        cpu.wstrb = 1'b0;
        cpu.addr  = '0;
        cpu.wdata = '0;
        cfg_iter  = 0;
        cfg_len   = 0;
        cfg_delay = 0;
        cfg_shift = 0;
        cfg_leaky = 1'b0;
        set_all('0, '0);
        @(negedge clk);

        test_reset();
        test_basic();
        test_lanes();
        test_saturate();
        test_degenerate();
        test_ignore_run_and_clear();
        test_reset_midrun();
        test_leaky();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
